imem_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage's address/response interface. It accepts word fetch requests, reads a local word-addressed instruction RAM, returns each word after a fixed LATENCY-cycle pipeline and buffers responses until the fetch side takes them. Flush discards everything in flight so that a redirected PC never receives stale words. A side load port preloads or patches program memory.

---
 rtl/imem_responder.sv | 153 +++++++++++++++
 tb/tb_imem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Fetch-side instruction RAM: LATENCY cycles from accept to resp_valid; req_ready drops at BUF_DEPTH outstanding.
// Define IMEM_ALIGN_CHECK_EN to flag misaligned fetches (resp_err=1, data 0) and drop misaligned load writes.
module imem_responder #(
   parameter int xlen      = 32,
   parameter int DEPTH     = 1024,
   parameter int LATENCY   = 2,
   parameter int BUF_DEPTH = LATENCY + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [xlen-1:0] req_addr,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [xlen-1:0] resp_data,
   output logic            resp_err,
   input  logic            flush,
   input  logic            load_we,
   input  logic [xlen-1:0] load_addr,
   input  logic [xlen-1:0] load_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   logic [xlen-1:0] mem_q [DEPTH];
   logic [AW-1:0]   rd_idx, wr_idx;
   logic            misalign, wr_en;
   logic [xlen-1:0] rd_dat;
   logic            rd_err;
   logic            accept, pop, push;
   logic            push_vld, push_err;
   logic [xlen-1:0] push_dat;
   logic            rdy_en_q;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [BUF_DEPTH-1:0][xlen-1:0] fifo_dat_q;
   logic [BUF_DEPTH-1:0]           fifo_err_q;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic            unused_addr_bits;

   assign rd_idx = req_addr[AW+1:2];
   assign wr_idx = load_addr[AW+1:2];
   assign unused_addr_bits = ^{req_addr[xlen-1:AW+2], req_addr[1:0],
                               load_addr[xlen-1:AW+2], load_addr[1:0]};

`ifdef IMEM_ALIGN_CHECK_EN
   assign misalign = |req_addr[1:0];
   assign wr_en    = load_we & ~|load_addr[1:0];
`else
   assign misalign = 1'b0;
   assign wr_en    = load_we;
`endif

   // Read-before-write: a same-cycle load to the fetched word is not visible to that fetch.
   assign rd_dat = misalign ? '0 : mem_q[rd_idx];
   assign rd_err = misalign;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= load_data;
   end

   assign req_ready = rdy_en_q & (out_cnt_q < CW'(BUF_DEPTH)) & ~flush;
   assign accept    = req_valid & req_ready;
   assign pop       = resp_valid & resp_ready & ~flush;
   assign push      = push_vld & ~flush;

   generate
      if (LATENCY == 1) begin : g_direct
         assign push_vld = accept;
         assign push_dat = rd_dat;
         assign push_err = rd_err;
      end else begin : g_pipe
         logic [LATENCY-2:0]           vld_q;
         logic [LATENCY-2:0][xlen-1:0] dat_q;
         logic [LATENCY-2:0]           err_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= '0;
               dat_q <= '0;
               err_q <= '0;
            end else begin
               vld_q[0] <= accept;
               dat_q[0] <= rd_dat;
               err_q[0] <= rd_err;
               for (int i = 1; i < LATENCY - 1; i++) begin
                  vld_q[i] <= vld_q[i-1];
                  dat_q[i] <= dat_q[i-1];
                  err_q[i] <= err_q[i-1];
               end
               if (flush) vld_q <= '0;
            end
         end

         assign push_vld = vld_q[LATENCY-2];
         assign push_dat = dat_q[LATENCY-2];
         assign push_err = err_q[LATENCY-2];
      end
   endgenerate

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      out_cnt_d  = out_cnt_q;
      fifo_cnt_d = fifo_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (flush) begin
         out_cnt_d  = '0;
         fifo_cnt_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (accept && !pop) out_cnt_d = out_cnt_q + CW'(1);
         if (pop && !accept) out_cnt_d = out_cnt_q - CW'(1);
         if (push && !pop)   fifo_cnt_d = fifo_cnt_q + CW'(1);
         if (pop && !push)   fifo_cnt_d = fifo_cnt_q - CW'(1);
         if (push)           wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)            rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q   <= 1'b0;
         out_cnt_q  <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_dat_q <= '0;
         fifo_err_q <= '0;
      end else begin
         rdy_en_q   <= 1'b1;
         out_cnt_q  <= out_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (push) begin
            fifo_dat_q[wr_ptr_q] <= push_dat;
            fifo_err_q[wr_ptr_q] <= push_err;
         end
      end
   end

   assign resp_valid = (fifo_cnt_q != '0);
   assign resp_data  = resp_valid ? fifo_dat_q[rd_ptr_q] : '0;
   assign resp_err   = resp_valid & fifo_err_q[rd_ptr_q];

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed vector table, hand sequences, then randomized traffic against a queue model.
module tb_imem_responder;
   localparam int LAT = 2;
   localparam int BUF = LAT + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
   logic        flush, load_we;
   logic [31:0] req_addr, resp_data, load_addr, load_data;

   imem_responder dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .flush(flush), .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
   );

   always #5 clk = ~clk;

   int    n_chk = 0;
   int    n_fail = 0;
   string phase = "reset";

   // Reference model: words wait in infl_q until their due edge, then sit in fifo_q until popped.
   typedef struct { logic [31:0] dat; bit err; int unsigned due; } item_t;
   item_t       infl_q[$];
   item_t       fifo_q[$];
   logic [31:0] mem_m [1024];
   int unsigned edge_n = 0;
   bit          rdy_en = 1'b0;

   typedef struct { bit rv; logic [31:0] addr; bit rr; bit exp_rdy; bit exp_vld; logic [31:0] exp_dat; } vec_t;
   vec_t vt[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s @%0t: got 0x%0h, expected 0x%0h", phase, name, $time, act, exp);
      end
   endfunction

   function automatic int unsigned widx(logic [31:0] a);
      return {22'b0, a[11:2]};
   endfunction

   function automatic bit misal(logic [31:0] a);
`ifdef IMEM_ALIGN_CHECK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_ready();
      return rdy_en && (infl_q.size() + fifo_q.size() < BUF) && !flush;
   endfunction

   function automatic void m_check();
      bit          ev;
      logic [31:0] ed;
      bit          ee;
      ev = fifo_q.size() > 0;
      ed = ev ? fifo_q[0].dat : 32'h0;
      ee = ev ? fifo_q[0].err : 1'b0;
      chk("model.req_ready", 32'(req_ready), 32'(m_ready()));
      chk("model.resp_valid", 32'(resp_valid), 32'(ev));
      chk("model.resp_data", resp_data, ed);
      chk("model.resp_err", 32'(resp_err), 32'(ee));
   endfunction

   function automatic void m_update();
      bit    acc, pop;
      item_t it;
      acc = req_valid && m_ready();
      pop = (fifo_q.size() > 0) && resp_ready && !flush;
      if (flush) begin
         infl_q.delete();
         fifo_q.delete();
      end else begin
         if (pop) void'(fifo_q.pop_front());
         if (acc) begin
            it.err = misal(req_addr);
            it.dat = it.err ? 32'h0 : mem_m[widx(req_addr)];
            it.due = edge_n + LAT - 1;
            infl_q.push_back(it);
         end
         while (infl_q.size() > 0 && infl_q[0].due == edge_n) fifo_q.push_back(infl_q.pop_front());
      end
      if (load_we && !misal(load_addr)) mem_m[widx(load_addr)] = load_data;
      edge_n++;
      rdy_en = 1'b1;
   endfunction

   task automatic drv(input bit rv, input logic [31:0] a, input bit rr, input bit fl,
                      input bit we, input logic [31:0] la, input logic [31:0] ld);
      req_valid = rv; req_addr = a; resp_ready = rr; flush = fl;
      load_we = we; load_addr = la; load_data = ld;
   endtask

   task automatic close_cycle();
      m_check();
      m_update();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit rv, input logic [31:0] a, input bit rr, input bit fl,
                      input bit we, input logic [31:0] la, input logic [31:0] ld);
      drv(rv, a, rr, fl, we, la, ld);
      @(negedge clk);
      close_cycle();
   endtask

   task automatic hchk(string n, bit rdy, bit vld, logic [31:0] dat, bit err);
      chk({n, ".req_ready"}, 32'(req_ready), 32'(rdy));
      chk({n, ".resp_valid"}, 32'(resp_valid), 32'(vld));
      chk({n, ".resp_data"}, resp_data, dat);
      chk({n, ".resp_err"}, 32'(resp_err), 32'(err));
   endtask

   // One cycle: drive, sample at negedge, compare to hand values, then advance model and clock.
   task automatic hcyc(string n, input bit rv, input logic [31:0] a, input bit rr, input bit fl,
                       input bit rdy, input bit vld, input logic [31:0] dat, input bit err);
      drv(rv, a, rr, fl, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      hchk(n, rdy, vld, dat, err);
      close_cycle();
   endtask

   function automatic void addv(bit rv, logic [31:0] a, bit rr, bit er, bit ev, logic [31:0] ed);
      vec_t v;
      v.rv = rv; v.addr = a; v.rr = rr; v.exp_rdy = er; v.exp_vld = ev; v.exp_dat = ed;
      vt.push_back(v);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, la;
      logic [31:0] exp_w;

      // Back-to-back fetches, then fill to BUF outstanding with resp_ready low and drain.
      addv(1, 32'h0, 1, 1, 0, 32'h0);
      addv(1, 32'h4, 1, 1, 0, 32'h0);
      addv(1, 32'h8, 1, 1, 1, 32'h11);
      addv(1, 32'hC, 1, 1, 1, 32'h22);
      addv(0, 32'h0, 1, 1, 1, 32'h33);
      addv(0, 32'h0, 1, 1, 1, 32'h44);
      addv(0, 32'h0, 1, 1, 0, 32'h0);
      addv(1, 32'h0, 0, 1, 0, 32'h0);
      addv(1, 32'h4, 0, 1, 0, 32'h0);
      addv(1, 32'h8, 0, 1, 1, 32'h11);
      addv(1, 32'hC, 0, 0, 1, 32'h11);
      addv(1, 32'hC, 0, 0, 1, 32'h11);
      addv(0, 32'h0, 1, 0, 1, 32'h11);
      addv(0, 32'h0, 1, 1, 1, 32'h22);
      addv(0, 32'h0, 1, 1, 1, 32'h33);
      addv(0, 32'h0, 1, 1, 0, 32'h0);

      rst_n = 1'b0;
      drv(0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      repeat (2) begin
         @(negedge clk);
         hchk("in_reset", 0, 0, 32'h0, 0);
      end
      rst_n = 1'b1;
      close_cycle();
      hcyc("post_reset", 0, 32'h0, 0, 0, 1, 0, 32'h0, 0);

      phase = "preload";
      cyc(0, 0, 0, 0, 1, 32'h0,  32'h11);
      cyc(0, 0, 0, 0, 1, 32'h4,  32'h22);
      cyc(0, 0, 0, 0, 1, 32'h8,  32'h33);
      cyc(0, 0, 0, 0, 1, 32'hC,  32'h44);
      cyc(0, 0, 0, 0, 1, 32'h10, 32'h55);

      phase = "table";
      for (int i = 0; i < vt.size(); i++) begin
         drv(vt[i].rv, vt[i].addr, vt[i].rr, 0, 0, 32'h0, 32'h0);
         @(negedge clk);
         chk($sformatf("row%0d.req_ready", i), 32'(req_ready), 32'(vt[i].exp_rdy));
         chk($sformatf("row%0d.resp_valid", i), 32'(resp_valid), 32'(vt[i].exp_vld));
         chk($sformatf("row%0d.resp_data", i), resp_data, vt[i].exp_dat);
         close_cycle();
      end

      phase = "flush_inflight";
      hcyc("acc0",       1, 32'h0, 0, 0, 1, 0, 32'h0, 0);
      hcyc("acc4",       1, 32'h4, 0, 0, 1, 0, 32'h0, 0);
      hcyc("flush",      0, 32'h0, 0, 1, 0, 1, 32'h11, 0);
      hcyc("after_fl",   1, 32'h8, 1, 0, 1, 0, 32'h0, 0);
      hcyc("wait",       0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
      hcyc("resp8",      0, 32'h0, 1, 0, 1, 1, 32'h33, 0);
      hcyc("empty",      0, 32'h0, 1, 0, 1, 0, 32'h0, 0);

      phase = "flush_collide";
      hcyc("acc0",       1, 32'h0, 0, 0, 1, 0, 32'h0, 0);
      hcyc("wait",       0, 32'h0, 0, 0, 1, 0, 32'h0, 0);
      hcyc("flush_pop",  1, 32'h4, 1, 1, 0, 1, 32'h11, 0);
      hcyc("after1",     0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
      hcyc("after2",     0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
      hcyc("after3",     0, 32'h0, 1, 0, 1, 0, 32'h0, 0);

      phase = "rd_wr_same";
      drv(1, 32'h10, 1, 0, 1, 32'h10, 32'hDEAD);
      @(negedge clk);
      hchk("rw", 1, 0, 32'h0, 0);
      close_cycle();
      hcyc("rd_next",    1, 32'h10, 1, 0, 1, 0, 32'h0, 0);
      hcyc("old",        0, 32'h0, 1, 0, 1, 1, 32'h55, 0);
      hcyc("new",        0, 32'h0, 1, 0, 1, 1, 32'hDEAD, 0);
      hcyc("empty",      0, 32'h0, 1, 0, 1, 0, 32'h0, 0);

      phase = "align";
      hcyc("req6",       1, 32'h6, 1, 0, 1, 0, 32'h0, 0);
      hcyc("wait",       0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
`ifdef IMEM_ALIGN_CHECK_EN
      hcyc("resp6",      0, 32'h0, 1, 0, 1, 1, 32'h0, 1);
      exp_w = 32'h22;
`else
      hcyc("resp6",      0, 32'h0, 1, 0, 1, 1, 32'h22, 0);
      exp_w = 32'hBAD;
`endif
      cyc(0, 32'h0, 1, 0, 1, 32'h5, 32'hBAD);
      hcyc("req4",       1, 32'h4, 1, 0, 1, 0, 32'h0, 0);
      hcyc("wait",       0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
      hcyc("resp4",      0, 32'h0, 1, 0, 1, 1, exp_w, 0);
      hcyc("wrap_req",   1, 32'hFFFF_F008, 1, 0, 1, 0, 32'h0, 0);
      hcyc("wait",       0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
      hcyc("wrap_resp",  0, 32'h0, 1, 0, 1, 1, 32'h33, 0);

      phase = "rand_preload";
      for (int i = 0; i < 64; i++) begin
         a = ($urandom() & 32'hFFFF_F000) | (32'(i) << 2);
         cyc(0, 32'h0, 1, 0, 1, a, $urandom());
      end

      phase = "random";
      for (int c = 0; c < 3000; c++) begin
         a  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2);
         la = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2);
         if ($urandom_range(0, 7) == 0) a  = a  | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) la = la | 32'($urandom_range(0, 3));
         cyc($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
             $urandom_range(0, 9) == 0, la, $urandom());
      end

      phase = "async_reset";
      drv(1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      hchk("in_reset", 0, 0, 32'h0, 0);
      infl_q.delete();
      fifo_q.delete();
      rdy_en = 1'b0;
      drv(0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      close_cycle();

      phase = "random_post_reset";
      for (int c = 0; c < 300; c++) begin
         a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2);
         cyc($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 5, $urandom_range(0, 31) == 0,
             1'b0, 32'h0, 32'h0);
      end
      repeat (8) cyc(0, 32'h0, 1, 0, 0, 32'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
